onchip_tdp_ram: RTL and testbench
=================================

ONCHIP_TDP_RAM -- requirements
Module: onchip_tdp_ram

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, word width in bits (multiple of 8).
REQ-002 The block SHALL have parameter ADDR_W, default 8, address width; depth = 2**ADDR_W.
REQ-003 The block SHALL have parameter RD_LAT, default 1, read latency in cycles (1 or 2).
REQ-004 The block SHALL have parameter WR_MODE, default READ_FIRST, per-port same-address read-during-write mode: READ_FIRST, WRITE_FIRST or NO_CHANGE.
REQ-005 The block SHALL have parameter CLEAR_ON_RST, default 1, which enables the zero-fill sweep after reset.
REQ-006 The block SHALL have port i_sys_clk, input, 1, the single clock for both ports.
REQ-007 The block SHALL have port i_rst, input, 1; reset is synchronous and active-high.
REQ-008 The block SHALL have ports i_ena / i_enb, input, 1, port A/B enables.
REQ-009 The block SHALL have ports i_wea / i_web, input, DATA_W/8, port A/B byte write enables.
REQ-010 The block SHALL have ports i_addra / i_addrb, input, ADDR_W, port A/B addresses.
REQ-011 The block SHALL have ports i_dina / i_dinb, input, DATA_W, port A/B write data.
REQ-012 The block SHALL have ports o_douta / o_doutb, output, DATA_W, port A/B read data.
REQ-013 The block SHALL have ports o_valida / o_validb, output, 1, which flag read data valid on o_douta/o_doutb.
REQ-014 The block SHALL have port o_ready, output, 1, which is high when the ports accept accesses.
REQ-015 The block SHALL have port o_collision, output, 1, a one-cycle pulse when both ports write the same address in one cycle.

Function
REQ-016 An access SHALL be accepted only when en=1 and o_ready=1; all port inputs SHALL be ignored while o_ready=0.
REQ-017 An accepted access SHALL write each byte lane whose we bit is 1 at the rising edge; lanes whose we bit is 0 SHALL keep their contents.
REQ-018 Every accepted access (read or write) SHALL produce a read; dout and valid SHALL appear exactly RD_LAT cycles after acceptance. RD_LAT=2 adds one output register stage.
REQ-019 On a same-port write, READ_FIRST SHALL return the old word. WRITE_FIRST SHALL return the merged new word. NO_CHANGE SHALL hold dout at its previous value with valid=0.
REQ-020 Cross-port same-address read-during-write SHALL return the old word on the reading port, whatever WR_MODE is.
REQ-021 On a dual write to the same address, the port A byte lanes SHALL win where both enables are set, port B lanes SHALL be written elsewhere, and o_collision SHALL pulse one cycle after the write.
REQ-022 dout SHALL hold its last value when no read is issued; valid SHALL be high only for the cycle(s) carrying new data.
REQ-023 The clear FSM SHALL have states IDLE, CLEAR, RUN. On reset with CLEAR_ON_RST=1 it SHALL enter CLEAR, write zero to addresses 0..2**ADDR_W-1 one per cycle, then enter RUN. On reset with CLEAR_ON_RST=0 it SHALL go directly to RUN.
REQ-024 o_ready SHALL be 1 only in RUN; the clear SHALL take exactly 2**ADDR_W cycles after reset deassertion.
REQ-025 The clear address counter SHALL stop at the last address (no wrap-around) and SHALL not be re-entered without a reset.
REQ-026 Addresses SHALL wrap naturally within ADDR_W; no out-of-range condition exists.

Reset
REQ-027 While i_rst=1, o_douta/o_doutb SHALL be 0, o_valida/o_validb SHALL be 0, o_ready SHALL be 0, o_collision SHALL be 0, and the pipeline registers SHALL be cleared.
REQ-028 Reset asserted mid-CLEAR or mid-access SHALL abort all in-flight reads (no valid is issued) and SHALL restart the sweep from address 0.
REQ-029 With CLEAR_ON_RST=0, memory contents SHALL be preserved across reset.

Structure
REQ-030 The WR_MODE encodings and the FSM state typedef SHALL reside in shared package onchip_ram_pkg.
REQ-031 The per-port read path (mode select, RD_LAT stages, valid) SHALL be sub-module onchip_ram_rd_pipe, instantiated twice.
REQ-032 The memory array SHALL be written for block-RAM inference, with no vendor IP instance.

Verification
REQ-033 Reset with CLEAR_ON_RST=1 and ADDR_W=8 -> o_ready=0 for 256 cycles, then 1; reads of addresses 0x00 and 0xFF return 0x0000.
REQ-034 Write A 0x12=0xBEEF, then read B 0x12 with RD_LAT=1 and then RD_LAT=2 -> o_doutb=0xBEEF with o_validb exactly 1 and 2 cycles later respectively.
REQ-035 Address 0x05=0x1111; port A writes 0x2222 with wea=2'b10 -> a later read returns 0x2211; WRITE_FIRST dout=0x2211, READ_FIRST dout=0x1111, NO_CHANGE validA=0.
REQ-036 A writes 0xAAAA and B writes 0x5555 to 0x40, both wea=web=2'b11, in the same cycle -> o_collision pulses once and a readback returns 0xAAAA.
REQ-037 Assert i_rst at clear address 0x80 -> the sweep restarts and o_ready rises 256 cycles after deassertion; a read issued one cycle before reset never produces valid.

Source files
------------

// File: rtl/onchip_ram_pkg.sv
// Shared types for the on-chip true-dual-port RAM: read-during-write modes
// and the post-reset clear FSM states.
package onchip_ram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    READ_FIRST  = 2'd0,
    WRITE_FIRST = 2'd1,
    NO_CHANGE   = 2'd2
  } wr_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } clr_state_e;

endpackage

// File: rtl/onchip_ram_rd_pipe.sv
// Per-port read path: same-port read-during-write selection, one or two
// output register stages and the matching valid flag.
module onchip_ram_rd_pipe
  import onchip_ram_pkg::*;
#(
  parameter int       DATA_W  = 16,
  parameter int       RD_LAT  = 1,
  parameter wr_mode_e WR_MODE = READ_FIRST
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_acc,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_old,
  input  logic [DATA_W-1:0] i_new,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_valid
);

  logic [DATA_W-1:0] r_dout_p1;
  logic              r_vld_p1;
  logic [DATA_W-1:0] w_dout;
  logic              w_vld;

  // Stage p1: capture the array word (or merged word) for an accepted access
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dout_p1 <= '0;
      r_vld_p1  <= 1'b0;
    end else if (i_acc) begin
      if (i_wr && (WR_MODE == NO_CHANGE)) begin
        r_vld_p1 <= 1'b0;
      end else begin
        r_dout_p1 <= (i_wr && (WR_MODE == WRITE_FIRST)) ? i_new : i_old;
        r_vld_p1  <= 1'b1;
      end
    end else begin
      r_vld_p1 <= 1'b0;
    end
  end

  // Stage p2: optional output register, holds its word between reads
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] r_dout_p2;
      logic              r_vld_p2;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_dout_p2 <= '0;
          r_vld_p2  <= 1'b0;
        end else begin
          r_vld_p2 <= r_vld_p1;
          if (r_vld_p1) r_dout_p2 <= r_dout_p1;
        end
      end

      assign w_dout = r_dout_p2;
      assign w_vld  = r_vld_p2;
    end else begin : g_lat1
      assign w_dout = r_dout_p1;
      assign w_vld  = r_vld_p1;
    end
  endgenerate

  // Reset masks the outputs immediately so an in-flight read never shows valid
  assign o_dout  = i_rst ? '0 : w_dout;
  assign o_valid = w_vld & ~i_rst;

endmodule

// File: rtl/onchip_tdp_ram.sv
// True-dual-port single-clock RAM with byte enables, configurable read
// latency and read-during-write mode, and an optional zero-fill after reset.
module onchip_tdp_ram
  import onchip_ram_pkg::*;
#(
  parameter int       DATA_W       = 16,
  parameter int       ADDR_W       = 8,
  parameter int       RD_LAT       = 1,
  parameter wr_mode_e WR_MODE      = READ_FIRST,
  parameter bit       CLEAR_ON_RST = 1'b1
) (
  input  logic                   i_sys_clk,
  input  logic                   i_rst,
  input  logic                   i_ena,
  input  logic                   i_enb,
  input  logic [DATA_W/8-1:0]    i_wea,
  input  logic [DATA_W/8-1:0]    i_web,
  input  logic [ADDR_W-1:0]      i_addra,
  input  logic [ADDR_W-1:0]      i_addrb,
  input  logic [DATA_W-1:0]      i_dina,
  input  logic [DATA_W-1:0]      i_dinb,
  output logic [DATA_W-1:0]      o_douta,
  output logic [DATA_W-1:0]      o_doutb,
  output logic                   o_valida,
  output logic                   o_validb,
  output logic                   o_ready,
  output logic                   o_collision
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 1 << ADDR_W;

  function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] din,
                                                input logic [NB-1:0]     we);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < NB; b++) begin
      if (we[b]) res[b*BYTE_W +: BYTE_W] = din[b*BYTE_W +: BYTE_W];
    end
    return res;
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];
  clr_state_e        r_state;
  logic [ADDR_W-1:0] r_clr_addr;
  logic              r_ready;
  logic              r_coll;

  logic              w_ready;
  logic              w_clr;
  logic              w_acc_a, w_acc_b;
  logic              w_wr_a, w_wr_b;
  logic [DATA_W-1:0] w_old_a, w_old_b;
  logic [DATA_W-1:0] w_new_a, w_new_b;

  assign w_ready = r_ready & ~i_rst;
  assign w_clr   = (r_state == ST_CLEAR) & ~i_rst;
  assign w_acc_a = i_ena & w_ready;
  assign w_acc_b = i_enb & w_ready;
  assign w_wr_a  = w_acc_a & (|i_wea);
  assign w_wr_b  = w_acc_b & (|i_web);
  assign w_old_a = r_mem[i_addra];
  assign w_old_b = r_mem[i_addrb];
  assign w_new_a = f_merge(w_old_a, i_dina, i_wea);
  assign w_new_b = f_merge(w_old_b, i_dinb, i_web);

  // Clear sweep: one address per cycle, parks on the last address
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      r_state    <= CLEAR_ON_RST ? ST_CLEAR : ST_RUN;
      r_clr_addr <= '0;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE:  r_state <= CLEAR_ON_RST ? ST_CLEAR : ST_RUN;
        ST_CLEAR: begin
          if (r_clr_addr == '1) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
          end
        end
        ST_RUN:   r_ready <= 1'b1;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Port B lanes are written first so port A overrides them on a shared address
  always_ff @(posedge i_sys_clk) begin
    if (w_clr) begin
      r_mem[r_clr_addr] <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (w_acc_b && i_web[b]) r_mem[i_addrb][b*BYTE_W +: BYTE_W] <= i_dinb[b*BYTE_W +: BYTE_W];
      end
      for (int b = 0; b < NB; b++) begin
        if (w_acc_a && i_wea[b]) r_mem[i_addra][b*BYTE_W +: BYTE_W] <= i_dina[b*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) r_coll <= 1'b0;
    else       r_coll <= w_wr_a & w_wr_b & (i_addra == i_addrb);
  end

  assign o_ready     = w_ready;
  assign o_collision = r_coll & ~i_rst;

  onchip_ram_rd_pipe #(
    .DATA_W  (DATA_W),
    .RD_LAT  (RD_LAT),
    .WR_MODE (WR_MODE)
  ) u_rd_a (
    .i_clk   (i_sys_clk),
    .i_rst   (i_rst),
    .i_acc   (w_acc_a),
    .i_wr    (w_wr_a),
    .i_old   (w_old_a),
    .i_new   (w_new_a),
    .o_dout  (o_douta),
    .o_valid (o_valida)
  );

  onchip_ram_rd_pipe #(
    .DATA_W  (DATA_W),
    .RD_LAT  (RD_LAT),
    .WR_MODE (WR_MODE)
  ) u_rd_b (
    .i_clk   (i_sys_clk),
    .i_rst   (i_rst),
    .i_acc   (w_acc_b),
    .i_wr    (w_wr_b),
    .i_old   (w_old_b),
    .i_new   (w_new_b),
    .o_dout  (o_doutb),
    .o_valid (o_validb)
  );

endmodule

// File: tb/tb_onchip_tdp_ram.sv
// Directed bench: four RAM configurations share one stimulus stream and are
// checked against hand-computed values.
module tb_onchip_tdp_ram;
  import onchip_ram_pkg::*;

  localparam int RF = 0;  // RD_LAT=1, READ_FIRST, clear on reset
  localparam int WF = 1;  // RD_LAT=2, WRITE_FIRST, clear on reset
  localparam int NC = 2;  // RD_LAT=1, NO_CHANGE, clear on reset
  localparam int PR = 3;  // RD_LAT=1, READ_FIRST, contents preserved

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ena, enb;
  logic [1:0]  wea, web;
  logic [7:0]  addra, addrb;
  logic [15:0] dina, dinb;
  logic [15:0] douta [4];
  logic [15:0] doutb [4];
  logic        va [4];
  logic        vb [4];
  logic        rdy [4];
  logic        col [4];

  int n_tests = 0;
  int n_fail  = 0;

  onchip_tdp_ram #(.DATA_W(16), .ADDR_W(8), .RD_LAT(1), .WR_MODE(READ_FIRST), .CLEAR_ON_RST(1'b1)) u_rf (
    .i_sys_clk(clk), .i_rst(rst), .i_ena(ena), .i_enb(enb), .i_wea(wea), .i_web(web),
    .i_addra(addra), .i_addrb(addrb), .i_dina(dina), .i_dinb(dinb),
    .o_douta(douta[RF]), .o_doutb(doutb[RF]), .o_valida(va[RF]), .o_validb(vb[RF]),
    .o_ready(rdy[RF]), .o_collision(col[RF]));

  onchip_tdp_ram #(.DATA_W(16), .ADDR_W(8), .RD_LAT(2), .WR_MODE(WRITE_FIRST), .CLEAR_ON_RST(1'b1)) u_wf (
    .i_sys_clk(clk), .i_rst(rst), .i_ena(ena), .i_enb(enb), .i_wea(wea), .i_web(web),
    .i_addra(addra), .i_addrb(addrb), .i_dina(dina), .i_dinb(dinb),
    .o_douta(douta[WF]), .o_doutb(doutb[WF]), .o_valida(va[WF]), .o_validb(vb[WF]),
    .o_ready(rdy[WF]), .o_collision(col[WF]));

  onchip_tdp_ram #(.DATA_W(16), .ADDR_W(8), .RD_LAT(1), .WR_MODE(NO_CHANGE), .CLEAR_ON_RST(1'b1)) u_nc (
    .i_sys_clk(clk), .i_rst(rst), .i_ena(ena), .i_enb(enb), .i_wea(wea), .i_web(web),
    .i_addra(addra), .i_addrb(addrb), .i_dina(dina), .i_dinb(dinb),
    .o_douta(douta[NC]), .o_doutb(doutb[NC]), .o_valida(va[NC]), .o_validb(vb[NC]),
    .o_ready(rdy[NC]), .o_collision(col[NC]));

  onchip_tdp_ram #(.DATA_W(16), .ADDR_W(8), .RD_LAT(1), .WR_MODE(READ_FIRST), .CLEAR_ON_RST(1'b0)) u_pr (
    .i_sys_clk(clk), .i_rst(rst), .i_ena(ena), .i_enb(enb), .i_wea(wea), .i_web(web),
    .i_addra(addra), .i_addrb(addrb), .i_dina(dina), .i_dinb(dinb),
    .o_douta(douta[PR]), .o_doutb(doutb[PR]), .o_valida(va[PR]), .o_validb(vb[PR]),
    .o_ready(rdy[PR]), .o_collision(col[PR]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ena = 1'b0; enb = 1'b0; wea = 2'b00; web = 2'b00;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; idle();
    addra = 8'h00; addrb = 8'h00; dina = 16'h0; dinb = 16'h0;
    tick(); tick();
    n_tests++; if (douta[RF] !== 16'h0) begin n_fail++; $display("FAIL rst_douta got %h want 0000", douta[RF]); end
    n_tests++; if (doutb[RF] !== 16'h0) begin n_fail++; $display("FAIL rst_doutb got %h want 0000", doutb[RF]); end
    n_tests++; if (va[RF] !== 1'b0 || vb[RF] !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b%b want 00", va[RF], vb[RF]); end
    n_tests++; if (rdy[RF] !== 1'b0 || rdy[PR] !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b/%b want 0/0", rdy[RF], rdy[PR]); end
    n_tests++; if (col[RF] !== 1'b0) begin n_fail++; $display("FAIL rst_collision got %b want 0", col[RF]); end
    rst = 1'b0;
    n = 0;
    while (rdy[RF] !== 1'b1 && n < 300) begin tick(); n++; end
    n_tests++; if (n !== 256) begin n_fail++; $display("FAIL clear_cycles got %0d want 256", n); end
    n_tests++; if (rdy[PR] !== 1'b1 || rdy[WF] !== 1'b1) begin n_fail++; $display("FAIL ready_after_clear got %b/%b want 1/1", rdy[PR], rdy[WF]); end
  endtask

  task automatic test_clear_readback();
    ena = 1'b1; addra = 8'h00; enb = 1'b1; addrb = 8'hFF;
    tick();
    n_tests++; if (douta[RF] !== 16'h0 || va[RF] !== 1'b1) begin n_fail++; $display("FAIL clr_rd_00 got %h v%b want 0000 v1", douta[RF], va[RF]); end
    n_tests++; if (doutb[RF] !== 16'h0 || vb[RF] !== 1'b1) begin n_fail++; $display("FAIL clr_rd_ff got %h v%b want 0000 v1", doutb[RF], vb[RF]); end
    idle(); tick();
    n_tests++; if (va[RF] !== 1'b0 || vb[RF] !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b%b want 00", va[RF], vb[RF]); end
  endtask

  task automatic test_rd_latency();
    ena = 1'b1; wea = 2'b11; addra = 8'h12; dina = 16'hBEEF;
    tick();
    n_tests++; if (douta[RF] !== 16'h0 || va[RF] !== 1'b1) begin n_fail++; $display("FAIL rf_write_old got %h v%b want 0000 v1", douta[RF], va[RF]); end
    idle(); enb = 1'b1; addrb = 8'h12;
    tick();
    n_tests++; if (doutb[RF] !== 16'hBEEF || vb[RF] !== 1'b1) begin n_fail++; $display("FAIL lat1_rd got %h v%b want beef v1", doutb[RF], vb[RF]); end
    n_tests++; if (vb[WF] !== 1'b0) begin n_fail++; $display("FAIL lat2_early_valid got %b want 0", vb[WF]); end
    idle(); tick();
    n_tests++; if (doutb[WF] !== 16'hBEEF || vb[WF] !== 1'b1) begin n_fail++; $display("FAIL lat2_rd got %h v%b want beef v1", doutb[WF], vb[WF]); end
    n_tests++; if (doutb[RF] !== 16'hBEEF || vb[RF] !== 1'b0) begin n_fail++; $display("FAIL lat1_hold got %h v%b want beef v0", doutb[RF], vb[RF]); end
    tick();
    n_tests++; if (vb[WF] !== 1'b0 || doutb[WF] !== 16'hBEEF) begin n_fail++; $display("FAIL lat2_hold got %h v%b want beef v0", doutb[WF], vb[WF]); end
  endtask

  task automatic test_byte_lanes();
    ena = 1'b1; wea = 2'b11; addra = 8'h05; dina = 16'h1111;
    tick();
    wea = 2'b10; dina = 16'h2222;
    tick();
    n_tests++; if (douta[RF] !== 16'h1111 || va[RF] !== 1'b1) begin n_fail++; $display("FAIL read_first got %h v%b want 1111 v1", douta[RF], va[RF]); end
    n_tests++; if (douta[NC] !== 16'h0 || va[NC] !== 1'b0) begin n_fail++; $display("FAIL no_change got %h v%b want 0000 v0", douta[NC], va[NC]); end
    n_tests++; if (douta[WF] !== 16'h1111 || va[WF] !== 1'b1) begin n_fail++; $display("FAIL write_first_full got %h v%b want 1111 v1", douta[WF], va[WF]); end
    idle(); tick();
    n_tests++; if (douta[WF] !== 16'h2211 || va[WF] !== 1'b1) begin n_fail++; $display("FAIL write_first_merge got %h v%b want 2211 v1", douta[WF], va[WF]); end
    ena = 1'b1; wea = 2'b00; addra = 8'h05;
    tick();
    n_tests++; if (douta[RF] !== 16'h2211 || va[RF] !== 1'b1) begin n_fail++; $display("FAIL lane_readback got %h v%b want 2211 v1", douta[RF], va[RF]); end
    n_tests++; if (douta[NC] !== 16'h2211 || va[NC] !== 1'b1) begin n_fail++; $display("FAIL nc_readback got %h v%b want 2211 v1", douta[NC], va[NC]); end
    idle(); tick();
  endtask

  task automatic test_collision();
    n_tests++; if (col[RF] !== 1'b0) begin n_fail++; $display("FAIL coll_quiet got %b want 0", col[RF]); end
    ena = 1'b1; enb = 1'b1; wea = 2'b11; web = 2'b11;
    addra = 8'h40; addrb = 8'h40; dina = 16'hAAAA; dinb = 16'h5555;
    tick();
    n_tests++; if (col[RF] !== 1'b1) begin n_fail++; $display("FAIL coll_pulse got %b want 1", col[RF]); end
    idle(); tick();
    n_tests++; if (col[RF] !== 1'b0) begin n_fail++; $display("FAIL coll_one_cycle got %b want 0", col[RF]); end
    enb = 1'b1; addrb = 8'h40;
    tick();
    n_tests++; if (doutb[RF] !== 16'hAAAA) begin n_fail++; $display("FAIL coll_winner got %h want aaaa", doutb[RF]); end
    // Cross-port: B reads while A writes the same address
    ena = 1'b1; wea = 2'b11; addra = 8'h40; dina = 16'h1234;
    enb = 1'b1; web = 2'b00; addrb = 8'h40;
    tick();
    n_tests++; if (doutb[RF] !== 16'hAAAA || vb[RF] !== 1'b1) begin n_fail++; $display("FAIL xport_rf got %h v%b want aaaa v1", doutb[RF], vb[RF]); end
    n_tests++; if (col[RF] !== 1'b0) begin n_fail++; $display("FAIL xport_no_coll got %b want 0", col[RF]); end
    idle(); tick();
    n_tests++; if (doutb[WF] !== 16'hAAAA || vb[WF] !== 1'b1) begin n_fail++; $display("FAIL xport_wf got %h v%b want aaaa v1", doutb[WF], vb[WF]); end
    // Partial overlap: A owns the low lane only
    ena = 1'b1; enb = 1'b1; wea = 2'b01; web = 2'b11;
    addra = 8'h41; addrb = 8'h41; dina = 16'h00CC; dinb = 16'h5566;
    tick();
    n_tests++; if (col[RF] !== 1'b1) begin n_fail++; $display("FAIL coll_partial got %b want 1", col[RF]); end
    idle(); enb = 1'b1; addrb = 8'h41;
    tick();
    n_tests++; if (doutb[RF] !== 16'h55CC) begin n_fail++; $display("FAIL coll_lanes got %h want 55cc", doutb[RF]); end
    idle(); tick();
  endtask

  task automatic test_reset_abort();
    int n;
    ena = 1'b1; wea = 2'b11; addra = 8'h33; dina = 16'hC0DE;
    tick();
    idle(); tick();
    ena = 1'b1; wea = 2'b00; addra = 8'h33;
    tick();
    rst = 1'b1; idle();
    #1;
    n_tests++; if (va[RF] !== 1'b0 || va[WF] !== 1'b0) begin n_fail++; $display("FAIL abort_now got %b/%b want 0/0", va[RF], va[WF]); end
    tick();
    n_tests++; if (va[WF] !== 1'b0 || va[RF] !== 1'b0) begin n_fail++; $display("FAIL abort_late got %b/%b want 0/0", va[RF], va[WF]); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 128; i++) tick();
    n_tests++; if (rdy[RF] !== 1'b0) begin n_fail++; $display("FAIL mid_clear_ready got %b want 0", rdy[RF]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (rdy[RF] !== 1'b1 && n < 300) begin tick(); n++; end
    n_tests++; if (n !== 256) begin n_fail++; $display("FAIL restart_cycles got %0d want 256", n); end
    ena = 1'b1; addra = 8'h33; enb = 1'b1; addrb = 8'h12;
    tick();
    n_tests++; if (douta[RF] !== 16'h0 || doutb[RF] !== 16'h0) begin n_fail++; $display("FAIL recleared got %h/%h want 0000/0000", douta[RF], doutb[RF]); end
    n_tests++; if (douta[PR] !== 16'hC0DE || va[PR] !== 1'b1) begin n_fail++; $display("FAIL preserved_a got %h v%b want c0de v1", douta[PR], va[PR]); end
    n_tests++; if (doutb[PR] !== 16'hBEEF) begin n_fail++; $display("FAIL preserved_b got %h want beef", doutb[PR]); end
    idle(); tick();
  endtask

  initial begin
    test_reset();
    test_clear_readback();
    test_rd_latency();
    test_byte_lanes();
    test_collision();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
